// File: rtl/cell_writeback.sv
// rtl/cell_writeback.sv - buffers 2x2 cell results and writes their words to result memory.
// Optional macro CELL_WB_ZERO_SKIP_EN: +0.0 words are consumed without a memory write.
module cell_writeback #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cell_valid,
  output logic               cell_ready,
  input  logic [129:0]       cell_in,
  input  logic [COORD_W-1:0] tile_row,
  input  logic [COORD_W-1:0] tile_col,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  row_stride,
  output logic               mem_wr_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic               mem_wr_ack,
  output logic               wb_idle,
  output logic [15:0]        words_written
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 130 + 2 * COORD_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT} state_t;

  state_t state, next_state;

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic               fifo_empty, fifo_full;
  logic               push, pop;

  logic [ENTRY_W-1:0] head;
  logic [129:0]       head_cell;
  logic [COORD_W-1:0] head_row, head_col;
  logic [ADDR_W-1:0]  row_ext, col_ext, row_off, a0_next;

  logic [127:0]       hold_cell;
  logic [1:0]         hold_shape;
  logic [ADDR_W-1:0]  a0;
  logic [1:0]         idx, elem, last_idx;
  logic [31:0]        cur_data;
  logic [ADDR_W-1:0]  cur_addr;
  logic               last_word, skip_word;
  logic               issue_word, advance, ack_taken;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cell_ready = !fifo_full;
  assign push       = cell_valid && !fifo_full;
  assign wb_idle    = fifo_empty && (state == S_IDLE) && !mem_wr_req;
  assign ack_taken  = (state == S_WAIT) && mem_wr_req && mem_wr_ack;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {cell_in, tile_row, tile_col};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Tile origin: A0 = base + 2*row*stride + 2*col, all modulo 2^ADDR_W.
  assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign head_cell = head[ENTRY_W-1 -: 130];
  assign head_row  = head[2*COORD_W-1:COORD_W];
  assign head_col  = head[COORD_W-1:0];
  assign row_ext   = ADDR_W'(head_row);
  assign col_ext   = ADDR_W'(head_col);
  assign row_off   = row_ext * row_stride;
  assign a0_next   = base_addr + (row_off << 1) + (col_ext << 1);

  // elem selects c11/c12/c21/c22 (0..3); a 2x1 tile walks c11 then c21.
  assign elem      = (hold_shape == 2'b10) ? {idx[0], 1'b0} : idx;
  assign cur_data  = hold_cell[{elem, 5'b0} +: 32];
  assign cur_addr  = a0 + (elem[1] ? row_stride : '0) + ADDR_W'(elem[0]);

  always_comb begin
    last_idx = 2'd0;
    case (hold_shape)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      2'b10:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  assign last_word = (idx == last_idx);

`ifdef CELL_WB_ZERO_SKIP_EN
  assign skip_word = (cur_data == 32'h0000_0000);
`else
  assign skip_word = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    issue_word = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) next_state = S_LOAD;
      end
      S_LOAD: begin
        if (fifo_empty) begin
          next_state = S_IDLE;
        end else begin
          pop        = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!skip_word) begin
          issue_word = 1'b1;
          next_state = S_WAIT;
        end else if (!last_word) begin
          advance = 1'b1;
        end else begin
          next_state = fifo_empty ? S_IDLE : S_LOAD;
        end
      end
      S_WAIT: begin
        if (mem_wr_req && mem_wr_ack) begin
          if (!last_word) begin
            advance    = 1'b1;
            next_state = S_ISSUE;
          end else begin
            next_state = fifo_empty ? S_IDLE : S_LOAD;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cell     <= '0;
      hold_shape    <= 2'b00;
      a0            <= '0;
      idx           <= 2'd0;
      mem_wr_req    <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
    end else begin
      if (pop) begin
        hold_cell  <= head_cell[127:0];
        hold_shape <= head_cell[129:128];
        a0         <= a0_next;
        idx        <= 2'd0;
      end else if (advance) begin
        idx <= idx + 2'd1;
      end
      if (issue_word) begin
        mem_wr_req <= 1'b1;
        mem_addr   <= cur_addr;
        mem_wdata  <= cur_data;
      end else if (ack_taken) begin
        mem_wr_req    <= 1'b0;
        words_written <= words_written + 16'd1;
      end
    end
  end

endmodule
